gate_test_sequencer: RTL and testbench

- Synthesizable on-chip self-test controller for a 2-input combinational gate under test (default target: NOR).
- Drives the gate's a/b operands through an exhaustive-count sweep, then a pseudo-random phase.
- Compares the DUT output against a golden reference output every cycle, and reports mismatch count, sample count and first-failure index.
- Sits between a test-start register and the gate pair (DUT + reference), replacing the simulation-only stimulus/checker loop in hardware.

---
 rtl/gate_test_pkg.sv | 27 ++
 rtl/gate_test_sequencer_lfsr16.sv | 46 ++++
 rtl/gate_test_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_gate_test_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_test_pkg
// Description : Shared types and constants for the gate self-test sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_test_pkg;

  // Sequencer phases
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    RANDOM = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Fibonacci feedback taps: bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // One shift-left step of the 16-bit Fibonacci LFSR
  function automatic logic [15:0] lfsr_advance(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_test_sequencer_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : 16-bit Fibonacci LFSR with synchronous load and step. An
//               all-zero seed would lock the register, so it is replaced by 1.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
  import gate_test_pkg::*;
#(
  parameter logic [15:0] RESET_SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  localparam logic [15:0] c_RESET_VAL = (RESET_SEED == 16'h0000) ? 16'h0001 : RESET_SEED;

  logic [15:0] r_q;
  logic [15:0] w_base;

  // Starting point for this cycle: the sanitised seed when loading, else current state
  always_comb begin
    w_base = r_q;
    if (load) begin
      w_base = (seed == 16'h0000) ? 16'h0001 : seed;
    end
  end

  // Load and step may coincide; the step then applies to the freshly loaded seed
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q <= c_RESET_VAL;
    end else if (load || step) begin
      r_q <= step ? lfsr_advance(w_base) : w_base;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/gate_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gate_test_sequencer
// Description : Self-test controller for a 2-input gate. Drives a counting
//               sweep then an LFSR phase on a/b, compares dut_out with ref_out
//               on every vector and reports counts and first-failure index.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int          SWEEP_LEN = 10,
  parameter int          RAND_LEN  = 200,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_out,
  input  logic             ref_out,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam int c_MAX_LEN = (SWEEP_LEN > RAND_LEN) ? SWEEP_LEN : RAND_LEN;
  localparam int c_IDX_W   = (c_MAX_LEN > 1) ? $clog2(c_MAX_LEN) : 1;
  localparam logic [c_IDX_W-1:0] c_SWEEP_LAST = c_IDX_W'(SWEEP_LEN - 1);
  localparam logic [c_IDX_W-1:0] c_RAND_LAST  = c_IDX_W'(RAND_LEN - 1);
  // Low bits of the seed as the LFSR will hold it right after a load
  localparam logic [1:0]       c_SEED_LOW = (LFSR_SEED == 16'h0000) ? 2'b01 : LFSR_SEED[1:0];
  localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

  state_t             r_state, w_state_nxt;
  logic               r_a, r_b, r_vec_valid, r_pass;
  logic [c_IDX_W-1:0] r_vec_idx, w_idx_nxt, w_idx_inc;
  logic [CNT_W-1:0]   r_sample, r_mismatch, r_fei, w_mismatch_nxt;
  logic               r_fev;
  logic               w_clear, w_lfsr_load, w_lfsr_step, w_load_vec, w_valid_nxt;
  logic               w_vec_a, w_vec_b, w_miscompare, w_enter_done;
  logic [1:0]         w_sweep_ab;
  logic [15:0]        w_lfsr_q;
  logic               w_unused_lfsr;

  lfsr16 #(
    .RESET_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .load   (w_lfsr_load),
    .step   (w_lfsr_step),
    .seed   (LFSR_SEED),
    .q      (w_lfsr_q)
  );

  // Only the two low LFSR bits become operands
  assign w_unused_lfsr = ^w_lfsr_q[15:2];

  assign w_idx_inc = r_vec_idx + c_IDX_W'(1);

  if (c_IDX_W > 1) begin : g_idx_wide
    assign w_sweep_ab = w_idx_inc[1:0];
  end else begin : g_idx_narrow
    assign w_sweep_ab = {1'b0, w_idx_inc};
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the vector/LFSR controls for the transition
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_lfsr_load = 1'b0;
    w_lfsr_step = 1'b0;
    w_load_vec  = 1'b0;
    w_vec_a     = r_a;
    w_vec_b     = r_b;
    w_idx_nxt   = r_vec_idx;
    w_valid_nxt = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_clear     = 1'b1;
          w_lfsr_load = 1'b1;
          w_idx_nxt   = '0;
          if (SWEEP_LEN != 0) begin
            w_state_nxt = SWEEP;
            w_load_vec  = 1'b1;
            w_vec_a     = 1'b0;
            w_vec_b     = 1'b0;
            w_valid_nxt = 1'b1;
          end else if (RAND_LEN != 0) begin
            w_state_nxt = RANDOM;
            w_lfsr_step = 1'b1;
            w_load_vec  = 1'b1;
            w_vec_b     = c_SEED_LOW[1];
            w_vec_a     = c_SEED_LOW[0];
            w_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      SWEEP: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (r_vec_idx == c_SWEEP_LAST) begin
          w_idx_nxt = '0;
          if (RAND_LEN != 0) begin
            w_state_nxt = RANDOM;
            w_lfsr_step = 1'b1;
            w_load_vec  = 1'b1;
            w_vec_b     = w_lfsr_q[1];
            w_vec_a     = w_lfsr_q[0];
            w_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = DONE;
          end
        end else begin
          w_idx_nxt   = w_idx_inc;
          w_load_vec  = 1'b1;
          w_vec_a     = w_sweep_ab[1];
          w_vec_b     = w_sweep_ab[0];
          w_valid_nxt = 1'b1;
        end
      end
      RANDOM: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (r_vec_idx == c_RAND_LAST) begin
          w_state_nxt = DONE;
        end else begin
          w_idx_nxt   = w_idx_inc;
          w_lfsr_step = 1'b1;
          w_load_vec  = 1'b1;
          w_vec_b     = w_lfsr_q[1];
          w_vec_a     = w_lfsr_q[0];
          w_valid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the current phase
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      SWEEP, RANDOM: busy = 1'b1;
      DONE:          done = 1'b1;
      default:       ;
    endcase
  end

  assign w_miscompare   = r_vec_valid && (dut_out != ref_out);
  assign w_mismatch_nxt = w_clear ? '0 :
                          (w_miscompare && (r_mismatch != c_CNT_MAX)) ? r_mismatch + CNT_W'(1) :
                          r_mismatch;
  // A start that jumps straight back into DONE (both lengths zero) still re-evaluates pass
  assign w_enter_done   = (w_state_nxt == DONE) && ((r_state != DONE) || start);

  // Operands, compare counters, first-failure capture and verdict
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_vec_idx   <= '0;
      r_vec_valid <= 1'b0;
      r_sample    <= '0;
      r_mismatch  <= '0;
      r_fev       <= 1'b0;
      r_fei       <= '0;
      r_pass      <= 1'b0;
    end else begin
      if (w_load_vec) begin
        r_a <= w_vec_a;
        r_b <= w_vec_b;
      end
      r_vec_idx   <= w_idx_nxt;
      r_vec_valid <= w_valid_nxt;
      r_mismatch  <= w_mismatch_nxt;
      if (w_clear) begin
        r_sample <= '0;
        r_fev    <= 1'b0;
        r_fei    <= '0;
      end else if (r_vec_valid) begin
        if (r_sample != c_CNT_MAX) begin
          r_sample <= r_sample + CNT_W'(1);
        end
        if (w_miscompare && !r_fev) begin
          r_fev <= 1'b1;
          r_fei <= r_sample;
        end
      end
      if (w_enter_done) begin
        r_pass <= (w_mismatch_nxt == '0);
      end else if (w_clear) begin
        r_pass <= 1'b0;
      end
    end
  end

  assign a               = r_a;
  assign b               = r_b;
  assign pass            = r_pass;
  assign sample_cnt      = r_sample;
  assign mismatch_cnt    = r_mismatch;
  assign first_err_valid = r_fev;
  assign first_err_idx   = r_fei;

endmodule
`default_nettype wire

// File: tb/tb_gate_test_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gate_test_sequencer
// Description : Self-checking bench: two sequencer instances (default sizing
//               and a short, 4-bit-counter variant with zero seed) driven by
//               directed and random start/abort traffic against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_test_sequencer;

  localparam int S0 = 10, R0 = 200, W0 = 16;
  localparam int S1 = 6,  R1 = 20,  W1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn = 1'b0;
  logic start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  int   mode0 = 0, mode1 = 3;  // 0 NOR, 1 stuck-at-0, 2 XNOR, 3 OR

  logic          a0, b0, busy0, done0, pass0, fev0, dut_out0, ref_out0;
  logic [W0-1:0] mis0, smp0, fei0;
  logic          a1, b1, busy1, done1, pass1, fev1, dut_out1, ref_out1;
  logic [W1-1:0] mis1, smp1, fei1;

  int errors = 0;
  int checks = 0;

  function automatic logic gate(input int md, input logic x, input logic y);
    case (md)
      0:       return ~(x | y);
      1:       return 1'b0;
      2:       return ~(x ^ y);
      default: return x | y;
    endcase
  endfunction

  assign dut_out0 = gate(mode0, a0, b0);
  assign ref_out0 = ~(a0 | b0);
  assign dut_out1 = gate(mode1, a1, b1);
  assign ref_out1 = ~(a1 | b1);

  gate_test_sequencer u_dut0 (
    .clk(clk), .resetn(resetn), .start(start0), .abort(abort0),
    .dut_out(dut_out0), .ref_out(ref_out0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch_cnt(mis0),
    .sample_cnt(smp0), .first_err_valid(fev0), .first_err_idx(fei0)
  );

  gate_test_sequencer #(
    .SWEEP_LEN(S1), .RAND_LEN(R1), .CNT_W(W1), .LFSR_SEED(16'h0000)
  ) u_dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .abort(abort1),
    .dut_out(dut_out1), .ref_out(ref_out1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(mis1),
    .sample_cnt(smp1), .first_err_valid(fev1), .first_err_idx(fei1)
  );

  // ---------------- behavioural model ----------------
  logic [1:0] vecs [2][256];   // {a,b} of every vector of a run, in order
  int  m_len [2] = '{S0 + R0, S1 + R1};
  int  m_max [2] = '{(1 << W0) - 1, (1 << W1) - 1};
  int  m_ph  [2] = '{0, 0};    // 0 idle, 1 running, 2 finished
  int  m_pos [2] = '{0, 0};
  int  m_smp [2] = '{0, 0};
  int  m_mis [2] = '{0, 0};
  int  m_fei [2] = '{0, 0};
  bit  m_a   [2] = '{0, 0};
  bit  m_b   [2] = '{0, 0};
  bit  m_fev [2] = '{0, 0};
  bit  m_pass[2] = '{0, 0};

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  task automatic build(input int k, input int sw, input int rn, input logic [15:0] seed);
    logic [15:0] q;
    q = (seed == 16'h0000) ? 16'h0001 : seed;
    for (int i = 0; i < sw; i++) vecs[k][i] = 2'(i);
    for (int i = 0; i < rn; i++) begin
      vecs[k][sw + i] = {q[0], q[1]};
      q = lfsr_next(q);
    end
  endtask

  task automatic model_reset(input int k);
    m_ph[k] = 0; m_pos[k] = 0; m_smp[k] = 0; m_mis[k] = 0; m_fei[k] = 0;
    m_a[k] = 0; m_b[k] = 0; m_fev[k] = 0; m_pass[k] = 0;
  endtask

  task automatic model_step(input int k, input logic st, input logic ab, input int md);
    if (m_ph[k] != 1) begin
      if (st) begin
        m_smp[k] = 0; m_mis[k] = 0; m_fei[k] = 0; m_fev[k] = 0; m_pass[k] = 0;
        if (m_len[k] > 0) begin
          m_ph[k] = 1; m_pos[k] = 0;
          {m_a[k], m_b[k]} = vecs[k][0];
        end else begin
          m_ph[k] = 2; m_pass[k] = 1;
        end
      end
    end else begin
      if (gate(md, m_a[k], m_b[k]) != ~(m_a[k] | m_b[k])) begin
        if (!m_fev[k]) begin m_fev[k] = 1; m_fei[k] = m_smp[k]; end
        if (m_mis[k] < m_max[k]) m_mis[k]++;
      end
      if (m_smp[k] < m_max[k]) m_smp[k]++;
      if (ab) m_ph[k] = 0;
      else if (m_pos[k] == m_len[k] - 1) begin
        m_ph[k] = 2; m_pass[k] = (m_mis[k] == 0);
      end else begin
        m_pos[k]++;
        {m_a[k], m_b[k]} = vecs[k][m_pos[k]];
      end
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, start0, abort0, mode0);
      model_step(1, start1, abort1, mode1);
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    check("u0.a",    32'(a0),    32'(m_a[0]));
    check("u0.b",    32'(b0),    32'(m_b[0]));
    check("u0.busy", 32'(busy0), 32'(m_ph[0] == 1));
    check("u0.done", 32'(done0), 32'(m_ph[0] == 2));
    check("u0.pass", 32'(pass0), 32'(m_pass[0]));
    check("u0.smp",  32'(smp0),  32'(m_smp[0]));
    check("u0.mis",  32'(mis0),  32'(m_mis[0]));
    check("u0.fev",  32'(fev0),  32'(m_fev[0]));
    check("u0.fei",  32'(fei0),  32'(m_fei[0]));
    check("u1.a",    32'(a1),    32'(m_a[1]));
    check("u1.b",    32'(b1),    32'(m_b[1]));
    check("u1.busy", 32'(busy1), 32'(m_ph[1] == 1));
    check("u1.done", 32'(done1), 32'(m_ph[1] == 2));
    check("u1.pass", 32'(pass1), 32'(m_pass[1]));
    check("u1.smp",  32'(smp1),  32'(m_smp[1]));
    check("u1.mis",  32'(mis1),  32'(m_mis[1]));
    check("u1.fev",  32'(fev1),  32'(m_fev[1]));
    check("u1.fei",  32'(fei1),  32'(m_fei[1]));
  end

  task automatic start_u0();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  // ---------------- stimulus and literal expectations ----------------
  initial begin
    int guard;
    build(0, S0, R0, 16'hACE1);
    build(1, S1, R1, 16'h0000);
    repeat (3) @(negedge clk);
    check("rst_a0",    32'(a0),    32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_smp0",  32'(smp0),  32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Correct NOR on u0 together with an OR fault on the saturating u1
    start0 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;                   // cycle 1
    check("t1_vec0_a", 32'(a0), 32'd0);
    check("t1_vec0_b", 32'(b0), 32'd0);
    check("t1_busy",   32'(busy0), 32'd1);
    repeat (6) @(negedge clk);                      // cycle 7
    check("t1_u1_rand0_a", 32'(a1), 32'd1);
    check("t1_u1_rand0_b", 32'(b1), 32'd0);
    repeat (4) @(negedge clk);                      // cycle 11
    check("t1_rand0_a", 32'(a0), 32'd1);
    check("t1_rand0_b", 32'(b0), 32'd0);
    check("t1_smp11",   32'(smp0), 32'd10);
    @(negedge clk);                                 // cycle 12
    check("t1_rand1_a", 32'(a0), 32'd1);
    check("t1_rand1_b", 32'(b0), 32'd1);
    repeat (15) @(negedge clk);                     // cycle 27
    check("t1_u1_done", 32'(done1), 32'd1);
    check("t1_u1_smp",  32'(smp1),  32'd15);
    check("t1_u1_mis",  32'(mis1),  32'd15);
    check("t1_u1_fei",  32'(fei1),  32'd0);
    check("t1_u1_pass", 32'(pass1), 32'd0);
    repeat (183) @(negedge clk);                    // cycle 210
    check("t1_done_early", 32'(done0), 32'd0);
    @(negedge clk);                                 // cycle 211
    check("t1_done", 32'(done0), 32'd1);
    check("t1_smp",  32'(smp0),  32'd210);
    check("t1_mis",  32'(mis0),  32'd0);
    check("t1_pass", 32'(pass0), 32'd1);
    check("t1_fev",  32'(fev0),  32'd0);

    // Stuck-at-0: sweep mismatches at vectors 0, 4, 8
    mode0 = 1;
    start_u0();
    repeat (10) @(negedge clk);                     // cycle 11
    check("t2_mis_sweep", 32'(mis0), 32'd3);
    check("t2_fei",       32'(fei0), 32'd0);
    check("t2_fev",       32'(fev0), 32'd1);
    repeat (200) @(negedge clk);
    check("t2_done", 32'(done0), 32'd1);
    check("t2_pass", 32'(pass0), 32'd0);

    // XNOR: sweep mismatches at vectors 3 and 7
    mode0 = 2;
    start_u0();
    repeat (10) @(negedge clk);
    check("t3_mis_sweep", 32'(mis0), 32'd2);
    check("t3_fei",       32'(fei0), 32'd3);
    repeat (200) @(negedge clk);
    check("t3_done", 32'(done0), 32'd1);

    // Abort while sample 5 is on the operands, then a clean rerun
    mode0 = 0;
    start_u0();
    repeat (5) @(negedge clk);                      // cycle 6
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    check("t4_smp",  32'(smp0),  32'd6);
    check("t4_busy", 32'(busy0), 32'd0);
    check("t4_done", 32'(done0), 32'd0);
    start_u0();
    check("t4_cleared", 32'(smp0), 32'd0);
    repeat (210) @(negedge clk);
    check("t4_smp2",  32'(smp0),  32'd210);
    check("t4_pass2", 32'(pass0), 32'd1);

    // Asynchronous reset in the middle of a run
    start_u0();
    repeat (49) @(negedge clk);                     // cycle 50
    #2 resetn = 1'b0;
    #1;
    check("t5_smp0",  32'(smp0),  32'd0);
    check("t5_busy0", 32'(busy0), 32'd0);
    check("t5_ab0",   32'({a0, b0}), 32'd0);
    check("t5_smp1",  32'(smp1),  32'd0);
    check("t5_done1", 32'(done1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    start_u0();
    repeat (210) @(negedge clk);
    check("t5_smp",  32'(smp0),  32'd210);
    check("t5_pass", 32'(pass0), 32'd1);

    // Random faults, starts (including while busy) and aborts
    for (int it = 0; it < 8; it++) begin
      mode0 = int'($urandom_range(0, 3));
      mode1 = int'($urandom_range(0, 3));
      start0 = 1'b1; start1 = 1'b1;
      abort0 = 1'($urandom_range(0, 1));
      abort1 = 1'($urandom_range(0, 1));
      @(negedge clk);
      for (int c = 0; c < 215; c++) begin
        start0 = ($urandom_range(0, 39) == 0);
        start1 = ($urandom_range(0, 39) == 0);
        abort0 = ($urandom_range(0, 149) == 0);
        abort1 = ($urandom_range(0, 59) == 0);
        @(negedge clk);
      end
      start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
      guard = 0;
      while ((m_ph[0] == 1 || m_ph[1] == 1) && guard < 400) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 400) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d cycles expected under 400", guard);
      end
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
